pwm_rgb_driver: RTL

PWM_RGB_DRIVER -- requirements
Module: pwm_rgb_driver

---
 rtl/pwm_rgb_driver.sv | 89 ++++++++
 1 files changed

// File: rtl/pwm_rgb_driver.sv
// pwm_rgb_driver: three-channel 8-bit PWM for an RGB LED.
// A prescaler divides clk down to PWM ticks; an 8-bit counter runs 0..254
// (255 ticks per period) and each channel is active while cnt < its shadow duty.
// Shadows reload only at period wrap (or continuously while idle), so a duty
// change never produces a partial period.
module pwm_rgb_driver #(
  parameter int unsigned DIV        = 390,  // clk cycles per PWM tick, 1..65535
  parameter bit          ACTIVE_LOW = 1'b0  // 1 inverts LED outputs (common anode)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] R_time_in,
  input  logic [7:0] G_time_in,
  input  logic [7:0] B_time_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       period_start
);

  localparam logic [15:0] DivLast = 16'(DIV - 1);
  localparam logic [7:0]  CntLast = 8'd254;

  typedef enum logic {StIdle, StRun} state_t;

  state_t      state;
  logic [15:0] pre;
  logic [7:0]  cnt;
  logic [7:0]  sh_r;
  logic [7:0]  sh_g;
  logic [7:0]  sh_b;

  logic tick;
  logic wrap;

  // Tick is gated by en so a falling en always wins over a pending tick.
  always_comb begin
    tick = en && (pre == DivLast);
    wrap = tick && (cnt == CntLast);
  end

  // Counters, shadows, state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      pre          <= '0;
      cnt          <= '0;
      sh_r         <= '0;
      sh_g         <= '0;
      sh_b         <= '0;
      led_r        <= ACTIVE_LOW;
      led_g        <= ACTIVE_LOW;
      led_b        <= ACTIVE_LOW;
      period_start <= 1'b0;
    end else if (!en) begin
      // Idle: park the counters and keep shadows tracking the inputs.
      state        <= StIdle;
      pre          <= '0;
      cnt          <= '0;
      sh_r         <= R_time_in;
      sh_g         <= G_time_in;
      sh_b         <= B_time_in;
      led_r        <= ACTIVE_LOW;
      led_g        <= ACTIVE_LOW;
      led_b        <= ACTIVE_LOW;
      period_start <= 1'b0;
    end else begin
      state <= StRun;
      // First run clk after idle starts a fresh period at cnt=0; so does a wrap.
      period_start <= (state == StIdle) || wrap;
      pre          <= (pre == DivLast) ? 16'd0 : pre + 16'd1;
      if (tick) begin
        cnt <= wrap ? 8'd0 : cnt + 8'd1;
      end
      // Shadows only change at the period boundary; with en held through a
      // reset they stay at zero until the first wrap.
      if (wrap) begin
        sh_r <= R_time_in;
        sh_g <= G_time_in;
        sh_b <= B_time_in;
      end
      led_r <= (cnt < sh_r) ^ ACTIVE_LOW;
      led_g <= (cnt < sh_g) ^ ACTIVE_LOW;
      led_b <= (cnt < sh_b) ^ ACTIVE_LOW;
    end
  end

endmodule
